// File: rtl/vinsn_dispatcher.sv
// rtl/vinsn_dispatcher.sv - issue splitter into per-VFU and operand FIFOs with per-VFU credit limits
// Optional: define VINSN_DISPATCH_BYPASS_EN to forward into empty FIFOs with zero-cycle latency.
module vinsn_dispatcher #(
  parameter int unsigned NrVFU       = 4,
  parameter int unsigned QueueDepth  = 2,
  parameter int unsigned MaxInflight = 4,
  parameter int unsigned VfuReqWidth = 64,
  parameter int unsigned OpReqWidth  = 32,
  localparam int unsigned TgtW  = (NrVFU > 1) ? $clog2(NrVFU) : 1,
  localparam int unsigned CntW  = $clog2(MaxInflight + 1),
  localparam int unsigned IdxW  = $clog2(QueueDepth),
  localparam int unsigned SlotW = (QueueDepth > 1) ? IdxW : 1,
  localparam int unsigned PtrW  = IdxW + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [TgtW-1:0]              issue_target_i,
  input  logic                         issue_needs_op_i,
  input  logic [VfuReqWidth-1:0]       issue_vfu_req_i,
  input  logic [OpReqWidth-1:0]        issue_op_req_i,
  output logic [NrVFU-1:0]             vfu_req_valid_o,
  input  logic [NrVFU-1:0]             vfu_req_ready_i,
  output logic [NrVFU*VfuReqWidth-1:0] vfu_req_o,
  output logic                         op_req_valid_o,
  input  logic                         op_req_ready_i,
  output logic [OpReqWidth-1:0]        op_req_o,
  input  logic [NrVFU-1:0]             vfu_done_i,
  output logic [NrVFU*CntW-1:0]        inflight_o,
  output logic                         err_o
);

  // Pointers carry one wrap bit above the slot index.
  logic [PtrW-1:0]        vfu_wr_ptr [NrVFU];
  logic [PtrW-1:0]        vfu_rd_ptr [NrVFU];
  logic [VfuReqWidth-1:0] vfu_mem    [NrVFU][QueueDepth];
  logic [PtrW-1:0]        op_wr_ptr, op_rd_ptr;
  logic [OpReqWidth-1:0]  op_mem     [QueueDepth];
  logic [CntW-1:0]        inflight_q [NrVFU];
  logic                   err_q;

  logic [NrVFU-1:0] vfu_empty, vfu_full, vfu_hit, vfu_push, vfu_pop;
  logic [NrVFU-1:0] credit_inc, credit_dec, credit_underflow;
  logic             op_empty, op_full, op_push, op_pop;
  logic             tgt_ok, accept, op_accept, illegal_tgt;
  logic [TgtW-1:0]  tgt_sel;

  function automatic logic [SlotW-1:0] slot(input logic [PtrW-1:0] p);
    return SlotW'({{(32-PtrW){1'b0}}, p} % QueueDepth);
  endfunction

  function automatic logic ptr_full(input logic [PtrW-1:0] w, input logic [PtrW-1:0] r);
    return (slot(w) == slot(r)) && (w[PtrW-1] != r[PtrW-1]);
  endfunction

  // Queue status and the accept decision; ready never looks at issue_valid_i.
  always_comb begin
    for (int k = 0; k < NrVFU; k++) begin
      vfu_empty[k] = (vfu_wr_ptr[k] == vfu_rd_ptr[k]);
      vfu_full[k]  = ptr_full(vfu_wr_ptr[k], vfu_rd_ptr[k]);
    end
    op_empty      = (op_wr_ptr == op_rd_ptr);
    op_full       = ptr_full(op_wr_ptr, op_rd_ptr);
    tgt_ok        = ({{(32-TgtW){1'b0}}, issue_target_i} < NrVFU);
    tgt_sel       = tgt_ok ? issue_target_i : '0;
    issue_ready_o = tgt_ok && !vfu_full[tgt_sel]
                    && (!issue_needs_op_i || !op_full)
                    && (inflight_q[tgt_sel] < CntW'(MaxInflight));
    accept        = issue_valid_i && issue_ready_o;
    op_accept     = accept && issue_needs_op_i;
    illegal_tgt   = issue_valid_i && !tgt_ok;
  end

  // Per-channel output presentation, push/pop strobes and credit bookkeeping.
  always_comb begin
    vfu_req_o  = '0;
    inflight_o = '0;
    for (int k = 0; k < NrVFU; k++) begin
      vfu_hit[k] = accept && (tgt_sel == TgtW'(k));
`ifdef VINSN_DISPATCH_BYPASS_EN
      vfu_req_valid_o[k] = !vfu_empty[k] || vfu_hit[k];
      vfu_req_o[k*VfuReqWidth +: VfuReqWidth] =
        vfu_empty[k] ? issue_vfu_req_i : vfu_mem[k][slot(vfu_rd_ptr[k])];
      vfu_push[k] = vfu_hit[k] && !(vfu_empty[k] && vfu_req_ready_i[k]);
`else
      vfu_req_valid_o[k] = !vfu_empty[k];
      vfu_req_o[k*VfuReqWidth +: VfuReqWidth] = vfu_mem[k][slot(vfu_rd_ptr[k])];
      vfu_push[k] = vfu_hit[k];
`endif
      vfu_pop[k]          = !vfu_empty[k] && vfu_req_ready_i[k];
      credit_inc[k]       = vfu_hit[k];
      credit_dec[k]       = vfu_done_i[k] && (inflight_q[k] != '0);
      credit_underflow[k] = vfu_done_i[k] && (inflight_q[k] == '0);
      inflight_o[k*CntW +: CntW] = inflight_q[k];
    end
`ifdef VINSN_DISPATCH_BYPASS_EN
    op_req_valid_o = !op_empty || op_accept;
    op_req_o       = op_empty ? issue_op_req_i : op_mem[slot(op_rd_ptr)];
    op_push        = op_accept && !(op_empty && op_req_ready_i);
`else
    op_req_valid_o = !op_empty;
    op_req_o       = op_mem[slot(op_rd_ptr)];
    op_push        = op_accept;
`endif
    op_pop         = !op_empty && op_req_ready_i;
  end

  // FIFO pointers, storage and credit counters; flush clears everything except the error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int k = 0; k < NrVFU; k++) begin
        vfu_wr_ptr[k] <= '0;
        vfu_rd_ptr[k] <= '0;
        inflight_q[k] <= '0;
      end
      op_wr_ptr <= '0;
      op_rd_ptr <= '0;
    end else begin
      for (int k = 0; k < NrVFU; k++) begin
        if (vfu_push[k]) begin
          vfu_mem[k][slot(vfu_wr_ptr[k])] <= issue_vfu_req_i;
          vfu_wr_ptr[k] <= vfu_wr_ptr[k] + 1'b1;
        end
        if (vfu_pop[k]) vfu_rd_ptr[k] <= vfu_rd_ptr[k] + 1'b1;
        case ({credit_inc[k], credit_dec[k]})
          2'b10:   inflight_q[k] <= inflight_q[k] + 1'b1;
          2'b01:   inflight_q[k] <= inflight_q[k] - 1'b1;
          default: inflight_q[k] <= inflight_q[k];
        endcase
      end
      if (op_push) begin
        op_mem[slot(op_wr_ptr)] <= issue_op_req_i;
        op_wr_ptr <= op_wr_ptr + 1'b1;
      end
      if (op_pop) op_rd_ptr <= op_rd_ptr + 1'b1;
    end
  end

  // Sticky error: credit underflow or an out-of-range target; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (!flush_i && ((|credit_underflow) || illegal_tgt)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_vinsn_dispatcher.sv
// tb/tb_vinsn_dispatcher.sv - scoreboard bench for vinsn_dispatcher with a queue-based reference model
module tb_vinsn_dispatcher;
  localparam int NV = 4;
  localparam int QD = 2;
  localparam int MI = 4;
  localparam int VW = 64;
  localparam int OW = 32;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            iv = 1'b0;
  logic            ir;
  logic [1:0]      tgt = '0;
  logic            nop = 1'b0;
  logic [VW-1:0]   vreq = '0;
  logic [OW-1:0]   oreq = '0;
  logic [NV-1:0]   vv;
  logic [NV-1:0]   vr = '0;
  logic [NV*VW-1:0] vo;
  logic            ov;
  logic            ordy = 1'b0;
  logic [OW-1:0]   oo;
  logic [NV-1:0]   done = '0;
  logic [NV*CW-1:0] infl;
  logic            err;

  int checks = 0;
  int errors = 0;

  logic [VW-1:0] exp_vfu [NV][$];
  logic [OW-1:0] exp_op [$];
  int            m_infl [NV];
  bit            m_err;
  bit            last_acc;

  vinsn_dispatcher dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .issue_valid_i(iv), .issue_ready_o(ir), .issue_target_i(tgt),
    .issue_needs_op_i(nop), .issue_vfu_req_i(vreq), .issue_op_req_i(oreq),
    .vfu_req_valid_o(vv), .vfu_req_ready_i(vr), .vfu_req_o(vo),
    .op_req_valid_o(ov), .op_req_ready_i(ordy), .op_req_o(oo),
    .vfu_done_i(done), .inflight_o(infl), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready(input int t, input bit needs_op);
    if (t >= NV) return 1'b0;
    return (exp_vfu[t].size() < QD) && (!needs_op || exp_op.size() < QD) && (m_infl[t] < MI);
  endfunction

  // Monitor: compares DUT outputs with the scoreboard heads and retires handshaken entries.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < NV; k++) exp_vfu[k].delete();
      exp_op.delete();
    end else begin
      for (int k = 0; k < NV; k++) begin
        chk($sformatf("vfu_valid[%0d]", k), vv[k], exp_vfu[k].size() != 0);
        if (exp_vfu[k].size() != 0) begin
          chk($sformatf("vfu_data[%0d]", k), vo[k*VW +: VW], exp_vfu[k][0]);
          if (vr[k]) void'(exp_vfu[k].pop_front());
        end
      end
      chk("op_valid", ov, exp_op.size() != 0);
      if (exp_op.size() != 0) begin
        chk("op_data", oo, 64'(exp_op[0]));
        if (ordy) void'(exp_op.pop_front());
      end
      if (flush) begin
        for (int k = 0; k < NV; k++) exp_vfu[k].delete();
        exp_op.delete();
      end
    end
  end

  // One clock of stimulus; entered and left 1 time unit after a rising edge.
  task automatic cycle(input bit v, input int t, input bit n, input logic [VW-1:0] vp,
                       input logic [OW-1:0] op, input logic [NV-1:0] vrdy, input bit ordy_in,
                       input logic [NV-1:0] dn, input bit fl);
    bit acc;
    iv = v; tgt = 2'(t); nop = n; vreq = vp; oreq = op;
    vr = vrdy; ordy = ordy_in; done = dn; flush = fl;
    #2;
    chk("issue_ready", ir, model_ready(t, n));
    for (int k = 0; k < NV; k++) chk($sformatf("inflight[%0d]", k), infl[k*CW +: CW], 64'(m_infl[k]));
    chk("err", err, m_err);
    acc = v && model_ready(t, n) && !fl;
    last_acc = acc;
    @(posedge clk);
    if (fl) begin
      for (int k = 0; k < NV; k++) m_infl[k] = 0;
    end else begin
      if (acc) begin
        exp_vfu[t].push_back(vp);
        if (n) exp_op.push_back(op);
      end
      for (int k = 0; k < NV; k++) begin
        if (dn[k]) begin
          if (m_infl[k] == 0) m_err = 1'b1;
          else m_infl[k]--;
        end
        if (acc && t == k) m_infl[k]++;
      end
    end
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) cycle(0, 0, 0, '0, '0, '1, 1'b1, '0, 1'b0);
  endtask

  task automatic do_reset();
    iv = 0; flush = 0; done = '0; vr = '0; ordy = 0; rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < NV; k++) m_infl[k] = 0;
    m_err = 1'b0;
  endtask

  initial begin
    int guard;
    logic [NV-1:0] dn;

    do_reset();
    chk("reset_vfu_valid", vv, 0);
    chk("reset_op_valid", ov, 0);
    chk("reset_inflight", infl, 0);
    chk("reset_err", err, 0);

    // Basic split: target 1 with operand.
    cycle(1, 1, 1, 64'hA5, 32'h3C, '1, 1'b1, '0, 1'b0);
    chk("basic_vfu_valid", vv, 4'b0010);
    chk("basic_vfu_data", vo[1*VW +: VW], 64'hA5);
    chk("basic_op_valid", ov, 1);
    chk("basic_op_data", oo, 64'h3C);
    chk("basic_inflight1", infl[1*CW +: CW], 1);
    idle(1);

    // Fill VFU 0 with its ready low; third issue must stall until space frees.
    cycle(1, 0, 0, 64'h100, '0, 4'b1110, 1'b1, '0, 1'b0);
    cycle(1, 0, 0, 64'h101, '0, 4'b1110, 1'b1, '0, 1'b0);
    chk("full_ready_low", ir, 0);
    cycle(1, 0, 0, 64'h102, '0, 4'b1110, 1'b1, '0, 1'b0);
    chk("full_third_rejected", last_acc, 0);
    guard = 0;
    do begin
      cycle(1, 0, 0, 64'h102, '0, '1, 1'b1, '0, 1'b0);
      guard++;
    end while (!last_acc && guard < 10);
    chk("full_third_accepted", last_acc, 1);
    chk("full_third_latency", guard, 2);
    idle(3);

    // Credit limit on VFU 2.
    for (int i = 0; i < MI; i++) cycle(1, 2, 0, 64'h200 + i, '0, '1, 1'b1, '0, 1'b0);
    chk("credit_ready_low", ir, 0);
    cycle(1, 2, 0, 64'h2FF, '0, '1, 1'b1, 4'b0100, 1'b0);
    chk("credit_done_same_cycle_stall", last_acc, 0);
    cycle(1, 2, 0, 64'h2FF, '0, '1, 1'b1, '0, 1'b0);
    chk("credit_fifth_accepted", last_acc, 1);
    chk("credit_count_four", infl[2*CW +: CW], 4);
    idle(2);

    // Underflow on VFU 3 sets the sticky error.
    cycle(0, 0, 0, '0, '0, '1, 1'b1, 4'b1000, 1'b0);
    chk("underflow_err", err, 1);
    chk("underflow_count", infl[3*CW +: CW], 0);
    cycle(0, 0, 0, '0, '0, '1, 1'b1, '0, 1'b1);
    chk("flush_keeps_err", err, 1);
    chk("flush_inflight", infl, 0);
    do_reset();
    chk("reset_clears_err", err, 0);

    // Operand FIFO keeps global accept order across channels.
    cycle(1, 0, 1, 64'h10, 32'h11, '1, 1'b0, '0, 1'b0);
    cycle(1, 1, 0, 64'h20, 32'h22, '1, 1'b0, '0, 1'b0);
    cycle(1, 0, 1, 64'h30, 32'h33, '1, 1'b0, '0, 1'b0);
    chk("op_order_head", oo, 64'h11);
    idle(3);
    chk("op_drained", ov, 0);

    // Flush with occupied FIFOs.
    cycle(1, 0, 1, 64'hF0, 32'hF0, '0, 1'b0, '0, 1'b0);
    cycle(1, 3, 1, 64'hF3, 32'hF3, '0, 1'b0, '0, 1'b0);
    cycle(0, 0, 0, '0, '0, '0, 1'b0, '0, 1'b1);
    chk("flush_vfu_valid", vv, 0);
    chk("flush_op_valid", ov, 0);
    chk("flush_inflight_zero", infl, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      dn = '0;
      for (int k = 0; k < NV; k++)
        if ((m_infl[k] > 0 && $urandom_range(2) == 0) || $urandom_range(299) == 0) dn[k] = 1'b1;
      cycle($urandom_range(3) != 0, $urandom_range(NV-1), $urandom_range(1),
            {$urandom, $urandom}, $urandom, 4'($urandom), $urandom_range(3) != 0,
            dn, $urandom_range(149) == 0);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/vinsn_dispatcher.md
Name: vinsn_dispatcher

Overview:
- Parametrised next-generation instruction launcher between `vinsn_decoder` and the execution back end.
- Splits each accepted issue request into a VFU request and an optional operand request.
- VFU requests are buffered in one FIFO per VFU channel; operand requests go to a single in-order FIFO toward `vrf_accesser`.
- Outstanding instructions are limited per VFU by credit counters returned through done pulses.

Parameters:
- NrVFU, 4, number of VFU channels (≥1).
- QueueDepth, 2, entries per VFU FIFO and in the operand FIFO (≥1, power of two).
- MaxInflight, 4, maximum accepted-but-not-done instructions per VFU (≥1).
- VfuReqWidth, 64, VFU request payload bits.
- OpReqWidth, 32, operand request payload bits.

Ports:
- clk_i  input  1  clock; single clock domain.
- rst_i  input  1  reset; synchronous, active-high.
- flush_i  input  1  synchronous clear of FIFOs and counters.
- issue_valid_i  input  1  issue request valid.
- issue_ready_o  output  1  issue request accepted when high with valid.
- issue_target_i  input  max(1,$clog2(NrVFU))  destination VFU index.
- issue_needs_op_i  input  1  request also needs an operand fetch.
- issue_vfu_req_i  input  VfuReqWidth  VFU payload.
- issue_op_req_i  input  OpReqWidth  operand payload.
- vfu_req_valid_o  output  NrVFU  per-channel valid.
- vfu_req_ready_i  input  NrVFU  per-channel ready.
- vfu_req_o  output  NrVFU*VfuReqWidth  per-channel payload; channel k is bits [k*VfuReqWidth +: VfuReqWidth].
- op_req_valid_o  output  1  operand request valid.
- op_req_ready_i  input  1  operand request ready.
- op_req_o  output  OpReqWidth  operand payload.
- vfu_done_i  input  NrVFU  one-cycle credit-return pulse per VFU.
- inflight_o  output  NrVFU*$clog2(MaxInflight+1)  per-VFU outstanding count.
- err_o  output  1  sticky credit underflow or illegal target flag.

Behaviour:
- Reset (rst_i high at a clock edge) and flush_i have the same effect:
  - all FIFOs emptied;
  - vfu_req_valid_o = 0, op_req_valid_o = 0, inflight_o = 0.
- Reset clears err_o. Flush does not clear err_o.
- rst_i has priority over flush_i, and flush_i has priority over all same-cycle events.
- Accept condition (t = issue_target_i), all must hold:
  - issue_valid_i is high;
  - t < NrVFU;
  - VFU FIFO t is not full;
  - either issue_needs_op_i = 0, or the operand FIFO is not full;
  - inflight[t] < MaxInflight.
- issue_ready_o is combinational from FIFO and counter state plus issue_target_i and issue_needs_op_i. It does not depend on issue_valid_i.
- On accept:
  - issue_vfu_req_i is pushed to FIFO t;
  - issue_op_req_i is pushed to the operand FIFO if issue_needs_op_i = 1;
  - inflight[t] is incremented.
- Output handshake:
  - vfu_req_valid_o[k] = FIFO k not empty, and vfu_req_o[k] is its head.
  - The head is popped when valid and ready are both high.
  - The operand FIFO works the same way.
  - Payload is held stable while valid is high and ready is low.
- Ordering:
  - the operand FIFO preserves global accept order;
  - each VFU FIFO preserves per-VFU order;
  - there is no ordering across VFU channels.
- Latency: accept to output valid is 1 cycle (registered FIFO storage).
- Full FIFO: push and pop in the same cycle on a full FIFO is allowed. Ready is still computed from pre-pop state, so a full FIFO deasserts ready even if a pop is pending.
- Empty FIFO: a pop request on an empty FIFO is impossible because valid is low.
- Credits:
  - a vfu_done_i[k] pulse decrements inflight[k];
  - accept and done on the same VFU in the same cycle leave the count unchanged;
  - the limit check uses the pre-update count.
  - done with inflight[k] = 0 is ignored, the count stays 0, and err_o is set.
- issue_valid_i with t ≥ NrVFU: not accepted (ready = 0) and err_o is set. This only applies when NrVFU is not a power of two.
- Pointer wrap-around: read and write pointers carry one extra wrap bit. Full is detected as equal index with wrap bits differing.

Optional Feature:
- Macro: VINSN_DISPATCH_BYPASS_EN.
- Defined, VFU channels:
  - when FIFO t is empty, the issue payload drives vfu_req_o[t] combinationally, with vfu_req_valid_o[t] = issue_valid_i && accept conditions;
  - if vfu_req_ready_i[t] is high that cycle, the entry is not enqueued (0-cycle latency);
  - otherwise it is enqueued normally.
- Defined, operand FIFO: same bypass rule applies.
- Defined: inflight is still incremented on accept.
- Not defined: strict 1-cycle latency, and outputs are driven purely from FIFO heads.

Test Plan:
- Reset, then issue target=1, needs_op=1, vfu payload 0xA5, op payload 0x3C with all ready=1:
  - next cycle vfu_req_valid_o = 4'b0010 with payload 0xA5;
  - op_req_valid_o = 1 with 0x3C;
  - inflight[1] = 1.
- Hold vfu_req_ready_i[0] = 0 and issue 3 requests to VFU 0 (QueueDepth=2):
  - first two are accepted, issue_ready_o = 0 for the third;
  - raising ready drains 2 entries in order, then the third is accepted.
- MaxInflight=4: accept 4 requests to VFU 2 with no done:
  - 5th is stalled;
  - done pulse on VFU 2 in the same cycle as the 5th valid still stalls that cycle (pre-update check);
  - the 5th is accepted next cycle and the count stays 4.
- vfu_done_i[3] with inflight[3] = 0 -> err_o rises and stays 1, inflight[3] stays 0; flush_i does not clear err_o; reset clears it.
- Interleave targets 0,1,0 with needs_op = 1,0,1 -> operand FIFO outputs exactly 2 entries in accept order.
- flush_i with occupied FIFOs -> next cycle all valids = 0 and inflight = 0. With bypass defined, an empty FIFO with ready=1 shows valid in the issue cycle.
